i2c_target: RTL and testbench



---
 rtl/i2c_target.sv | 170 +++++++++++++++++
 tb/tb_i2c_target.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target with an 8-bit register-pointer back end: filtered SCL/SDA inputs,
// START/STOP decode, fixed 7-bit address match, ACK and read-data drive on SDA.
module i2c_target #(
  parameter logic [6:0]  ADDRESS    = 7'h50,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i2c_scl_in,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_drive_n,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  localparam logic [2:0] CNT_MAX = 3'(FILTER_LEN - 1);

  // index 0 = SCL, index 1 = SDA
  logic [1:0]      r_s1, r_s2, r_f, r_fd;
  logic [1:0][2:0] r_cnt;

  state_t     r_state, w_state_nx;
  logic [6:0] r_shift;
  logic [2:0] r_bitcnt;
  logic [7:0] r_tx, r_addr, r_wdata;
  logic       r_drive_n, r_we, r_re, r_re_d, r_busy;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_sda, w_last, w_match;
  logic [7:0] w_byte;
  logic       w_shift, w_count, w_we, w_re, w_ld_ptr, w_inc;
  logic       w_busy_set, w_busy_clr, w_drive_n;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_s1  <= '1;
      r_s2  <= '1;
      r_f   <= '1;
      r_fd  <= '1;
      r_cnt <= '0;
    end else begin
      r_s1 <= {i2c_sda_in, i2c_scl_in};
      r_s2 <= r_s1;
      r_fd <= r_f;
      // filtered value flips only after FILTER_LEN consecutive differing samples
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_s2[i] == r_f[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_f[i]   <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 3'd1;
        end
      end
    end
  end

  assign w_scl_rise = r_f[0] & ~r_fd[0];
  assign w_scl_fall = ~r_f[0] & r_fd[0];
  assign w_start    = r_f[0] & r_fd[0] & ~r_f[1] & r_fd[1];
  assign w_stop     = r_f[0] & r_fd[0] & r_f[1] & ~r_fd[1];
  assign w_sda      = r_f[1];
  assign w_byte     = {r_shift, w_sda};
  assign w_last     = (r_bitcnt == 3'd7);
  assign w_match    = (w_byte[7:1] == ADDRESS);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_stop) begin
      w_state_nx = S_IDLE;
    end else if (w_start) begin
      w_state_nx = S_ADDR;
    end else if (w_scl_rise) begin
      case (r_state)
        S_ADDR:     if (w_last) w_state_nx = w_match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: w_state_nx = r_shift[0] ? S_RDATA : S_PTR;
        S_PTR:      if (w_last) w_state_nx = S_PTR_ACK;
        S_PTR_ACK:  w_state_nx = S_WDATA;
        S_WDATA:    if (w_last) w_state_nx = S_WACK;
        S_WACK:     w_state_nx = S_WDATA;
        S_RDATA:    if (w_last) w_state_nx = S_RACK;
        S_RACK:     w_state_nx = w_sda ? S_IGNORE : S_RDATA;
        default:    w_state_nx = r_state;
      endcase
    end
  end

  always_comb begin
    w_shift    = 1'b0;
    w_count    = 1'b0;
    w_we       = 1'b0;
    w_re       = 1'b0;
    w_ld_ptr   = 1'b0;
    w_inc      = 1'b0;
    w_busy_set = 1'b0;
    w_busy_clr = 1'b0;
    w_drive_n  = r_drive_n;
    if (w_start || w_stop) begin
      w_busy_clr = 1'b1;
      w_drive_n  = 1'b1;
    end else if (w_scl_rise) begin
      case (r_state)
        S_ADDR:     begin w_shift = 1'b1; w_count = 1'b1; w_busy_set = w_last & w_match; end
        S_ADDR_ACK: w_re = r_shift[0];
        S_PTR:      begin w_shift = 1'b1; w_count = 1'b1; w_ld_ptr = w_last; end
        S_WDATA:    begin w_shift = 1'b1; w_count = 1'b1; w_we = w_last; end
        S_RDATA:    begin w_count = 1'b1; w_inc = w_last; end
        S_RACK:     begin w_re = ~w_sda; w_busy_clr = w_sda; end
        default:    ;
      endcase
    end else if (w_scl_fall) begin
      case (r_state)
        S_ADDR_ACK, S_PTR_ACK, S_WACK: w_drive_n = 1'b0;
        S_RDATA:                       w_drive_n = r_tx[3'd7 - r_bitcnt];
        default:                       w_drive_n = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_drive_n <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_re_d    <= 1'b0;
      r_busy    <= 1'b0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
    end else begin
      r_drive_n <= w_drive_n;
      r_we      <= w_we;
      r_re      <= w_re;
      r_re_d    <= r_re;
      if (r_re_d) r_tx <= reg_rdata;
      if (w_we) r_wdata <= w_byte;
      if (w_ld_ptr)           r_addr <= w_byte;
      else if (r_we || w_inc) r_addr <= r_addr + 8'd1;
      if (w_busy_clr)      r_busy <= 1'b0;
      else if (w_busy_set) r_busy <= 1'b1;
      if (w_start || w_stop) r_bitcnt <= '0;
      else if (w_count)      r_bitcnt <= r_bitcnt + 3'd1;
      if (w_shift) r_shift <= w_byte[6:0];
    end
  end

  assign i2c_sda_drive_n = r_drive_n;
  assign reg_addr        = r_addr;
  assign reg_wdata       = r_wdata;
  assign reg_we          = r_we;
  assign reg_re          = r_re;
  assign busy            = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on the pins, a register
// memory back end, and monitors that log write/read strobes and SDA drive.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int unsigned H = 20;  // SCL half period in clk cycles

  logic       clk = 1'b0;
  logic       resetn, tb_scl, tb_sda, sda_drive_n, sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  always #5 clk = ~clk;
  assign sda_bus = tb_sda & sda_drive_n;

  i2c_target #(.ADDRESS(7'h50), .FILTER_LEN(3)) dut (
    .clk(clk), .resetn(resetn), .i2c_scl_in(tb_scl), .i2c_sda_in(sda_bus),
    .i2c_sda_drive_n(sda_drive_n), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
  );

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  logic [15:0]  we_q [$];
  logic [7:0]   re_q [$];
  int unsigned  low_cnt;
  always @(negedge clk) begin
    if (reg_we) we_q.push_back({reg_addr, reg_wdata});
    if (reg_re) re_q.push_back(reg_addr);
    if (!sda_drive_n) low_cnt++;
  end

  int unsigned n_run = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    tb_sda = 1'b1; clks(H/2);
    tb_scl = 1'b1; clks(H);
    tb_sda = 1'b0; clks(H);
    tb_scl = 1'b0; clks(H/2);
  endtask

  task automatic i2c_stop();
    tb_sda = 1'b0; clks(H/2);
    tb_scl = 1'b1; clks(H);
    tb_sda = 1'b1; clks(H);
  endtask

  // gmode 1: 2-cycle low glitch on SCL while high; gmode 2: same on SDA
  task automatic send_bit(input logic b, input int gmode, output logic rb);
    tb_sda = b; clks(H/2);
    tb_scl = 1'b1;
    if (gmode == 1) begin
      clks(H/4); tb_scl = 1'b0; clks(2); tb_scl = 1'b1; clks(H/4 - 2);
    end else if (gmode == 2) begin
      clks(H/4); tb_sda = 1'b0; clks(2); tb_sda = b; clks(H/4 - 2);
    end else begin
      clks(H/2);
    end
    rb = sda_bus; clks(H/2);
    tb_scl = 1'b0; clks(H/2);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gmode, input int gidx, output logic ack);
    logic rb;
    for (int i = 0; i < 8; i++) send_bit(d[7-i], (i == gidx) ? gmode : 0, rb);
    send_bit(1'b1, 0, ack);
  endtask

  task automatic recv_byte(output logic [7:0] d);
    logic rb;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, 0, rb);
      d = {d[6:0], rb};
    end
  endtask

  typedef struct {
    logic [7:0] abyte;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       match;
  } vec_t;

  initial begin
    vec_t       vt [6];
    logic       a0, a1, a2, a3, rb;
    logic [7:0] d, exp_ptr;

    vt[0] = '{8'hA0, 8'h20, 8'h11, 1'b1};
    vt[1] = '{8'hA0, 8'hFF, 8'h80, 1'b1};
    vt[2] = '{8'hA2, 8'h30, 8'h44, 1'b0};
    vt[3] = '{8'h00, 8'h31, 8'h45, 1'b0};
    vt[4] = '{8'hA0, 8'h7F, 8'h3C, 1'b1};
    vt[5] = '{8'hB0, 8'h32, 8'h46, 1'b0};

    tb_scl = 1'b1; tb_sda = 1'b1; resetn = 1'b0; low_cnt = 0;
    clks(3);
    chk("rst_drive_n", sda_drive_n, 1'b1);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_we", reg_we, 1'b0);
    chk("rst_re", reg_re, 1'b0);
    chk("rst_busy", busy, 1'b0);
    resetn = 1'b1;
    clks(5);

    exp_ptr = 8'h00;
    for (int i = 0; i < 6; i++) begin
      we_q.delete(); low_cnt = 0;
      i2c_start();
      send_byte(vt[i].abyte, 0, 0, a0);
      send_byte(vt[i].ptr, 0, 0, a1);
      send_byte(vt[i].data, 0, 0, a2);
      i2c_stop(); clks(4);
      chk($sformatf("row%0d_addr_ack", i), a0, !vt[i].match);
      chk($sformatf("row%0d_ptr_ack", i), a1, !vt[i].match);
      chk($sformatf("row%0d_data_ack", i), a2, !vt[i].match);
      chk($sformatf("row%0d_we_count", i), we_q.size(), vt[i].match ? 1 : 0);
      if (vt[i].match) begin
        exp_ptr = vt[i].ptr + 8'd1;
        if (we_q.size() == 1) chk($sformatf("row%0d_we_entry", i), we_q[0], {vt[i].ptr, vt[i].data});
      end else begin
        chk($sformatf("row%0d_no_drive", i), low_cnt, 0);
      end
      chk($sformatf("row%0d_ptr", i), reg_addr, exp_ptr);
      chk($sformatf("row%0d_busy", i), busy, 1'b0);
    end

    // write burst with pointer auto-increment
    we_q.delete();
    i2c_start();
    send_byte(8'hA0, 0, 0, a0);
    chk("burst_busy", busy, 1'b1);
    send_byte(8'h10, 0, 0, a1);
    send_byte(8'h5A, 0, 0, a2);
    send_byte(8'hC3, 0, 0, a3);
    i2c_stop(); clks(4);
    chk("burst_acks", {a0, a1, a2, a3}, 4'b0000);
    chk("burst_we_count", we_q.size(), 2);
    if (we_q.size() == 2) begin
      chk("burst_we0", we_q[0], 16'h105A);
      chk("burst_we1", we_q[1], 16'h11C3);
    end
    chk("burst_ptr", reg_addr, 8'h12);

    // fill FE, FF, 00 across the wrap, then read back with a repeated START
    we_q.delete();
    i2c_start();
    send_byte(8'hA0, 0, 0, a0);
    send_byte(8'hFE, 0, 0, a0);
    send_byte(8'h11, 0, 0, a0);
    send_byte(8'h22, 0, 0, a0);
    send_byte(8'h33, 0, 0, a0);
    i2c_stop(); clks(4);
    chk("fill_we_count", we_q.size(), 3);
    if (we_q.size() == 3) chk("fill_wrap_we", we_q[2], 16'h0033);

    re_q.delete();
    i2c_start();
    send_byte(8'hA0, 0, 0, a0);
    send_byte(8'hFE, 0, 0, a1);
    i2c_start();
    send_byte(8'hA1, 0, 0, a2);
    chk("rd_acks", {a0, a1, a2}, 3'b000);
    recv_byte(d); chk("rd_byte0", d, 8'h11); send_bit(1'b0, 0, rb);
    recv_byte(d); chk("rd_byte1", d, 8'h22); send_bit(1'b0, 0, rb);
    recv_byte(d); chk("rd_byte2", d, 8'h33);
    chk("rd_busy_before_nack", busy, 1'b1);
    send_bit(1'b1, 0, rb);
    chk("rd_busy_after_nack", busy, 1'b0);
    i2c_stop(); clks(4);
    chk("rd_re_count", re_q.size(), 3);
    if (re_q.size() == 3) chk("rd_re_addrs", {re_q[0], re_q[1], re_q[2]}, 24'hFEFF00);
    chk("rd_ptr", reg_addr, 8'h01);

    // STOP after four data bits
    we_q.delete();
    i2c_start();
    send_byte(8'hA0, 0, 0, a0);
    send_byte(8'h40, 0, 0, a0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 0, rb);
    i2c_stop(); clks(4);
    chk("midstop_we", we_q.size(), 0);
    chk("midstop_ptr", reg_addr, 8'h40);
    chk("midstop_busy", busy, 1'b0);

    // repeated START in the middle of a data byte
    i2c_start();
    send_byte(8'hA0, 0, 0, a0);
    send_byte(8'h50, 0, 0, a0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0, rb);
    i2c_start();
    send_byte(8'hA0, 0, 0, a1);
    send_byte(8'h60, 0, 0, a2);
    send_byte(8'h77, 0, 0, a3);
    i2c_stop(); clks(4);
    chk("midsr_acks", {a1, a2, a3}, 3'b000);
    chk("midsr_we_count", we_q.size(), 1);
    if (we_q.size() == 1) chk("midsr_we", we_q[0], 16'h6077);
    chk("midsr_ptr", reg_addr, 8'h61);

    // short glitches on SCL and SDA during a write
    we_q.delete();
    i2c_start();
    send_byte(8'hA0, 0, 0, a0);
    send_byte(8'h70, 0, 0, a1);
    send_byte(8'hA5, 1, 2, a2);
    send_byte(8'h5A, 2, 1, a3);
    i2c_stop(); clks(4);
    chk("glitch_acks", {a0, a1, a2, a3}, 4'b0000);
    chk("glitch_we_count", we_q.size(), 2);
    if (we_q.size() == 2) chk("glitch_we", {we_q[0], we_q[1]}, 32'h70A5_715A);
    chk("glitch_ptr", reg_addr, 8'h72);

    // reset while the address ACK is driven
    we_q.delete(); re_q.delete();
    i2c_start();
    for (int i = 0; i < 8; i++) send_bit(i == 0 || i == 2, 0, rb);
    chk("rstack_driven", sda_drive_n, 1'b0);
    tb_sda = 1'b1;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("rstack_drive_n", sda_drive_n, 1'b1);
    chk("rstack_addr", reg_addr, 8'h00);
    chk("rstack_wdata", reg_wdata, 8'h00);
    chk("rstack_we_re", {reg_we, reg_re}, 2'b00);
    chk("rstack_busy", busy, 1'b0);
    @(negedge clk); resetn = 1'b1;
    clks(2);
    low_cnt = 0;
    send_bit(1'b1, 0, rb);
    send_byte(8'hA0, 0, 0, a0);
    chk("rstack_no_ack", {rb, a0}, 2'b11);
    chk("rstack_no_drive", low_cnt, 0);
    i2c_stop(); clks(4);
    i2c_start();
    send_byte(8'hA0, 0, 0, a0);
    send_byte(8'h12, 0, 0, a1);
    send_byte(8'h34, 0, 0, a2);
    i2c_stop(); clks(4);
    chk("rstack_fresh_acks", {a0, a1, a2}, 3'b000);
    chk("rstack_fresh_we_count", we_q.size(), 1);
    if (we_q.size() == 1) chk("rstack_fresh_we", we_q[0], 16'h1234);
    chk("rstack_no_re", re_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
